// File: rtl/surface_scheduler_pkg.sv
// Shared coordinate widths and types for the surface scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: SCX/SCY vertex widths, CX/CY raster counter widths, TOTAL_LED
// pixel width, quad_t descriptor and sched_state_t FSM encoding.
package surface_scheduler_pkg;

  localparam int SCX       = 8;
  localparam int SCY       = 8;
  localparam int CX        = 8;
  localparam int CY        = 8;
  localparam int TOTAL_LED = 4;

  typedef struct packed {
    logic [SCX-1:0]       ax;
    logic [SCY-1:0]       ay;
    logic [SCX-1:0]       bx;
    logic [SCY-1:0]       by;
    logic [SCX-1:0]       cx;
    logic [SCY-1:0]       cy;
    logic [SCX-1:0]       dx;
    logic [SCY-1:0]       dy;
    logic [TOTAL_LED-1:0] block;
  } quad_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/surface_slot_bank.sv
// Double-buffered quad descriptor store: writes land in back, copy_i snapshots back into front.
// Latency: write/copy take effect at the next clock edge; read mux is combinational.
// Backpressure: none, every write is accepted; out-of-range indices are dropped.
// Ports: clk/reset, wr_en_i/wr_idx_i/wr_quad_i/wr_enable_i write port, copy_i
// copy strobe, rd_idx_i -> rd_quad_o/rd_vld_o read port.
module surface_slot_bank
  import surface_scheduler_pkg::*;
#(
  parameter int N_SURF = 6,
  parameter int IDXW   = $clog2(N_SURF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  quad_t           wr_quad_i,
  input  logic            wr_enable_i,
  input  logic            copy_i,
  input  logic [IDXW-1:0] rd_idx_i,
  output quad_t           rd_quad_o,
  output logic            rd_vld_o
);

  quad_t             back_q  [N_SURF];
  quad_t             front_q [N_SURF];
  logic [N_SURF-1:0] back_vld_q;
  logic [N_SURF-1:0] front_vld_q;
  logic              wr_hit;

  assign wr_hit = wr_en_i && (int'(wr_idx_i) < N_SURF);

  // Only the valid bits need reset; stale geometry behind a cleared bit is never used.
  always_ff @(posedge clk) begin
    if (reset) begin
      back_vld_q  <= '0;
      front_vld_q <= '0;
    end else begin
      if (copy_i) front_vld_q <= back_vld_q;
      if (wr_hit) back_vld_q[wr_idx_i] <= wr_enable_i;
    end
  end

  // Non-blocking copy means front receives back as it was before a same-cycle write.
  always_ff @(posedge clk) begin
    if (copy_i) begin
      for (int i = 0; i < N_SURF; i++) front_q[i] <= back_q[i];
    end
    if (wr_hit) back_q[wr_idx_i] <= wr_quad_i;
  end

  // Read returns the front as it will be after this edge, so a scan launched
  // in the same cycle as a copy already sees the new geometry.
  always_comb begin
    quad_t q;
    logic  v;
    q         = '0;
    v         = 1'b0;
    rd_quad_o = '0;
    rd_vld_o  = 1'b0;
    if (int'(rd_idx_i) < N_SURF) begin
      q = copy_i ? back_q[rd_idx_i]     : front_q[rd_idx_i];
      v = copy_i ? back_vld_q[rd_idx_i] : front_vld_q[rd_idx_i];
      rd_quad_o       = q;
      rd_quad_o.block = v ? q.block : '0;
      rd_vld_o        = v;
    end
  end

endmodule

// File: rtl/surface_scheduler.sv
// Time-multiplexes one external quad rasterizer across N_SURF descriptor slots per pixel.
// Latency: pix_en to pixel_valid is N_SURF+1 cycles (k+2 for a slot-k hit with early exit).
// Backpressure: pix_en while busy is dropped and flags sticky overrun; writes always accepted.
// Ports: wr_* descriptor write, frame_start copy request, pix_en/h_count/v_count
// pixel request, rast_* drive to rasterizer, rast_pixel result, pixel_out/pixel_valid,
// busy, overrun. Optional macro: SURFACE_SCHED_EARLY_EXIT_EN (stop scan at first hit).
module surface_scheduler
  import surface_scheduler_pkg::*;
#(
  parameter int                   N_SURF = 6,
  parameter int                   IDXW   = $clog2(N_SURF),
  parameter logic [TOTAL_LED-1:0] BG     = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [IDXW-1:0]      wr_idx,
  input  quad_t                wr_quad,
  input  logic                 wr_enable,
  input  logic                 frame_start,
  input  logic                 pix_en,
  input  logic [CX-1:0]        h_count,
  input  logic [CY-1:0]        v_count,
  output logic [SCX-1:0]       rast_ax,
  output logic [SCY-1:0]       rast_ay,
  output logic [SCX-1:0]       rast_bx,
  output logic [SCY-1:0]       rast_by,
  output logic [SCX-1:0]       rast_cx,
  output logic [SCY-1:0]       rast_cy,
  output logic [SCX-1:0]       rast_dx,
  output logic [SCY-1:0]       rast_dy,
  output logic [TOTAL_LED-1:0] rast_block,
  output logic [CX-1:0]        rast_h,
  output logic [CY-1:0]        rast_v,
  input  logic [TOTAL_LED-1:0] rast_pixel,
  output logic [TOTAL_LED-1:0] pixel_out,
  output logic                 pixel_valid,
  output logic                 busy,
  output logic                 overrun
);

  sched_state_t         state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 hit_q, hit_d;
  logic [TOTAL_LED-1:0] res_q, res_d;
  quad_t                rast_q, rast_d;
  logic                 rast_vld_q, rast_vld_d;
  logic [CX-1:0]        rast_h_q, rast_h_d;
  logic [CY-1:0]        rast_v_q, rast_v_d;
  logic [TOTAL_LED-1:0] pixel_out_q, pixel_out_d;
  logic                 pixel_valid_q, pixel_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 swap_q, swap_d;

  logic            copy;
  logic [IDXW-1:0] rd_idx;
  quad_t           rd_quad;
  logic            rd_vld;
  logic            hit_now;
  logic            last_slot;
  logic            scan_end;

  assign wr_ready = ~reset;
  assign copy     = (state_q == IDLE) && swap_q;

  surface_slot_bank #(
    .N_SURF (N_SURF),
    .IDXW   (IDXW)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (wr_valid && wr_ready),
    .wr_idx_i    (wr_idx),
    .wr_quad_i   (wr_quad),
    .wr_enable_i (wr_enable),
    .copy_i      (copy),
    .rd_idx_i    (rd_idx),
    .rd_quad_o   (rd_quad),
    .rd_vld_o    (rd_vld)
  );

  // rast_vld_q tracks whether the slot currently on rast_* is enabled.
  assign hit_now   = (state_q == SCAN) && !hit_q && rast_vld_q && (rast_pixel != '0);
  assign last_slot = (idx_q == IDXW'(N_SURF - 1));

`ifdef SURFACE_SCHED_EARLY_EXIT_EN
  assign scan_end = last_slot || hit_now;
`else
  assign scan_end = last_slot;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hit_d         = hit_q;
    res_d         = res_q;
    rast_d        = rast_q;
    rast_vld_d    = rast_vld_q;
    rast_h_d      = rast_h_q;
    rast_v_d      = rast_v_q;
    pixel_out_d   = pixel_out_q;
    pixel_valid_d = 1'b0;
    overrun_d     = overrun_q;
    swap_d        = (swap_q && !copy) || frame_start;
    rd_idx        = '0;

    case (state_q)
      IDLE: begin
        if (pix_en) begin
          rast_h_d   = h_count;
          rast_v_d   = v_count;
          idx_d      = '0;
          hit_d      = 1'b0;
          rast_d     = rd_quad;
          rast_vld_d = rd_vld;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (hit_now) begin
          hit_d = 1'b1;
          res_d = rast_pixel;
        end
        if (scan_end) begin
          // Resolve here so pixel_out is already valid during the DONE cycle.
          pixel_out_d   = hit_now ? rast_pixel : (hit_q ? res_q : BG);
          pixel_valid_d = 1'b1;
          state_d       = DONE;
        end else begin
          rd_idx     = idx_q + IDXW'(1);
          idx_d      = idx_q + IDXW'(1);
          rast_d     = rd_quad;
          rast_vld_d = rd_vld;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pix_en && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      hit_q         <= 1'b0;
      res_q         <= '0;
      rast_q        <= '0;
      rast_vld_q    <= 1'b0;
      rast_h_q      <= '0;
      rast_v_q      <= '0;
      pixel_out_q   <= '0;
      pixel_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      swap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hit_q         <= hit_d;
      res_q         <= res_d;
      rast_q        <= rast_d;
      rast_vld_q    <= rast_vld_d;
      rast_h_q      <= rast_h_d;
      rast_v_q      <= rast_v_d;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= pixel_valid_d;
      overrun_q     <= overrun_d;
      swap_q        <= swap_d;
    end
  end

  assign rast_ax     = rast_q.ax;
  assign rast_ay     = rast_q.ay;
  assign rast_bx     = rast_q.bx;
  assign rast_by     = rast_q.by;
  assign rast_cx     = rast_q.cx;
  assign rast_cy     = rast_q.cy;
  assign rast_dx     = rast_q.dx;
  assign rast_dy     = rast_q.dy;
  assign rast_block  = rast_q.block;
  assign rast_h      = rast_h_q;
  assign rast_v      = rast_v_q;
  assign pixel_out   = pixel_out_q;
  assign pixel_valid = pixel_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_surface_scheduler.sv
// Self-checking bench for surface_scheduler with a bounding-box rasterizer stand-in.
// Latency: expects N+1 cycles per pixel (k+2 for a slot-k hit with SURFACE_SCHED_EARLY_EXIT_EN).
// Backpressure: exercises overrun on early pix_en; writes are never stalled.
module tb_surface_scheduler;
  import surface_scheduler_pkg::*;

  localparam int N    = 6;
  localparam int IDXW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [IDXW-1:0]      wr_idx;
  quad_t                wr_quad;
  logic                 wr_enable;
  logic                 frame_start;
  logic                 pix_en;
  logic [CX-1:0]        h_count;
  logic [CY-1:0]        v_count;
  logic [SCX-1:0]       rast_ax, rast_bx, rast_cx, rast_dx;
  logic [SCY-1:0]       rast_ay, rast_by, rast_cy, rast_dy;
  logic [TOTAL_LED-1:0] rast_block;
  logic [CX-1:0]        rast_h;
  logic [CY-1:0]        rast_v;
  logic [TOTAL_LED-1:0] rast_pixel;
  logic [TOTAL_LED-1:0] pixel_out;
  logic                 pixel_valid;
  logic                 busy;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  surface_scheduler #(.N_SURF(N)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_quad(wr_quad), .wr_enable(wr_enable),
    .frame_start(frame_start), .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
    .rast_ax(rast_ax), .rast_ay(rast_ay), .rast_bx(rast_bx), .rast_by(rast_by),
    .rast_cx(rast_cx), .rast_cy(rast_cy), .rast_dx(rast_dx), .rast_dy(rast_dy),
    .rast_block(rast_block), .rast_h(rast_h), .rast_v(rast_v), .rast_pixel(rast_pixel),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Stand-in rasterizer: colour if (h,v) lies in the quad's bounding box, inclusive.
  function automatic int raster(input quad_t q, input int h, input int v);
    int x0, x1, y0, y1;
    x0 = min4(int'(q.ax), int'(q.bx), int'(q.cx), int'(q.dx));
    x1 = max4(int'(q.ax), int'(q.bx), int'(q.cx), int'(q.dx));
    y0 = min4(int'(q.ay), int'(q.by), int'(q.cy), int'(q.dy));
    y1 = max4(int'(q.ay), int'(q.by), int'(q.cy), int'(q.dy));
    if (h >= x0 && h <= x1 && v >= y0 && v <= y1) return int'(q.block);
    return 0;
  endfunction

  quad_t rq;
  always_comb begin
    rq       = '0;
    rq.ax    = rast_ax; rq.ay = rast_ay; rq.bx = rast_bx; rq.by = rast_by;
    rq.cx    = rast_cx; rq.cy = rast_cy; rq.dx = rast_dx; rq.dy = rast_dy;
    rq.block = rast_block;
    rast_pixel = TOTAL_LED'(raster(rq, int'(rast_h), int'(rast_v)));
  end

  function automatic quad_t mkq(input int x0, input int y0, input int x1, input int y1,
                                input int blk);
    quad_t q;
    q.ax = SCX'(x0); q.ay = SCY'(y0);
    q.bx = SCX'(x1); q.by = SCY'(y0);
    q.cx = SCX'(x1); q.cy = SCY'(y1);
    q.dx = SCX'(x0); q.dy = SCY'(y1);
    q.block = TOTAL_LED'(blk);
    return q;
  endfunction

  // Reference model: front/back snapshots and first-enabled-nonzero-wins resolution.
  quad_t mback [N];
  quad_t mfront[N];
  bit    eback [N];
  bit    efront[N];

  function automatic void ref_px(input int h, input int v, output int pix, output int k);
    bit found;
    int r;
    found = 1'b0;
    pix   = 0;
    k     = -1;
    for (int i = 0; i < N; i++) begin
      r = raster(mfront[i], h, v);
      if (!found && efront[i] && r != 0) begin
        found = 1'b1;
        pix   = r;
        k     = i;
      end
    end
  endfunction

  function automatic int exp_lat(input int k);
`ifdef SURFACE_SCHED_EARLY_EXIT_EN
    return (k < 0) ? N + 1 : k + 2;
`else
    return (k < 0) ? N + 1 : N + 1;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input quad_t q, input bit en);
    wr_valid  = 1'b1;
    wr_idx    = IDXW'(idx);
    wr_quad   = q;
    wr_enable = en;
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic frame_copy();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Issue one pixel; optionally pulse frame_start or a second pix_en c edges later.
  task automatic run_pixel(input int h, input int v, input int exp_pix, input int elat,
                           input string nm, input int fs_at, input int pe2_at);
    int lat;
    int nvld;
    lat     = -1;
    nvld    = 0;
    h_count = CX'(h);
    v_count = CY'(v);
    pix_en  = 1'b1;
    for (int c = 1; c <= N + 6; c++) begin
      tick();
      pix_en      = 1'b0;
      frame_start = 1'b0;
      if (c == 1) begin
        check({nm, " busy"}, 32'(busy), 32'd1);
        check({nm, " rast_h"}, 32'(rast_h), 32'(h));
      end
      if (pixel_valid) begin
        nvld++;
        if (lat < 0) begin
          lat = c;
          check({nm, " pix"}, 32'(pixel_out), 32'(exp_pix));
        end
      end
      if (c == fs_at) frame_start = 1'b1;
      if (c == pe2_at) pix_en = 1'b1;
    end
    check({nm, " lat"}, 32'(lat), 32'(elat));
    check({nm, " nvld"}, 32'(nvld), 32'd1);
    check({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int idx; int x0; int y0; int x1; int y1; int blk; int en;
  } cfg_t;

  typedef struct {
    int h; int v; int pix; int k;
  } vec_t;

  cfg_t cfg [5];
  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pix, k, nv;
    quad_t q;

    cfg[0] = '{0, 10, 10, 20, 20, 3, 1};
    cfg[1] = '{1, 30, 30, 50, 50, 5, 1};
    cfg[2] = '{2, 0, 0, 100, 100, 15, 0};
    cfg[3] = '{3, 40, 40, 60, 60, 9, 1};
    cfg[4] = '{5, 70, 70, 80, 80, 10, 1};

    vecs[0]  = '{15, 15, 3, 0};
    vecs[1]  = '{5, 5, 0, -1};
    vecs[2]  = '{35, 35, 5, 1};
    vecs[3]  = '{45, 45, 5, 1};
    vecs[4]  = '{55, 55, 9, 3};
    vecs[5]  = '{10, 10, 3, 0};
    vecs[6]  = '{20, 20, 3, 0};
    vecs[7]  = '{21, 21, 0, -1};
    vecs[8]  = '{75, 75, 10, 5};
    vecs[9]  = '{90, 90, 0, -1};
    vecs[10] = '{50, 50, 5, 1};
    vecs[11] = '{60, 60, 9, 3};
    vecs[12] = '{61, 61, 0, -1};

    reset = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_quad = '0; wr_enable = 1'b0;
    frame_start = 1'b0; pix_en = 1'b0; h_count = '0; v_count = '0;

    // Reset state
    tick();
    tick();
    check("rst wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post-rst wr_ready", 32'(wr_ready), 32'd1);
    tick();
    check("rst pixel_out", 32'(pixel_out), 32'd0);
    check("rst pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst rast_ax", 32'(rast_ax), 32'd0);
    check("rst rast_block", 32'(rast_block), 32'd0);
    check("rst rast_h", 32'(rast_h), 32'd0);

    // Single square in slot 0
    wr(0, mkq(10, 10, 20, 20, 3), 1'b1);
    frame_copy();
    run_pixel(15, 15, 3, exp_lat(0), "sq in", -1, -1);
    run_pixel(5, 5, 0, exp_lat(-1), "sq out", -1, -1);

    // Full configuration and vector table
    for (int i = 0; i < 5; i++)
      wr(cfg[i].idx, mkq(cfg[i].x0, cfg[i].y0, cfg[i].x1, cfg[i].y1, cfg[i].blk), cfg[i].en[0]);
    wr(7, mkq(120, 120, 130, 130, 7), 1'b1);
    frame_copy();
    for (int i = 0; i < 13; i++)
      run_pixel(vecs[i].h, vecs[i].v, vecs[i].pix, exp_lat(vecs[i].k), $sformatf("vec%0d", i), -1, -1);
    run_pixel(125, 125, 0, exp_lat(-1), "oob idx dropped", -1, -1);

    // Disable slot 1: overlap now resolves to slot 3
    wr(1, mkq(30, 30, 50, 50, 5), 1'b0);
    frame_copy();
    run_pixel(45, 45, 9, exp_lat(3), "slot1 disabled", -1, -1);

    // Mid-frame write is invisible until the copy
    wr(2, mkq(100, 100, 110, 110, 12), 1'b1);
    tick();
    tick();
    run_pixel(105, 105, 0, exp_lat(-1), "no swap yet", -1, -1);
    frame_copy();
    run_pixel(105, 105, 12, exp_lat(2), "after swap", -1, -1);

    // frame_start during SCAN: current pixel keeps old data
    wr(2, mkq(100, 100, 110, 110, 6), 1'b1);
    run_pixel(105, 105, 12, exp_lat(2), "fs in scan", 2, -1);
    run_pixel(105, 105, 6, exp_lat(2), "fs applied", -1, -1);

    // Write in the copy cycle lands in back only
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr(5, mkq(70, 70, 80, 80, 11), 1'b1);
    run_pixel(75, 75, 10, exp_lat(5), "wr+copy old", -1, -1);
    frame_copy();
    run_pixel(75, 75, 11, exp_lat(5), "wr+copy new", -1, -1);

    // Overrun: second pix_en 3 cycles later is ignored
    check("ovr before", 32'(overrun), 32'd0);
    run_pixel(200, 200, 0, exp_lat(-1), "ovr", -1, 3);
    check("ovr sticky", 32'(overrun), 32'd1);
    run_pixel(15, 15, 3, exp_lat(0), "after ovr", -1, -1);
    check("ovr still", 32'(overrun), 32'd1);

    // Reset in SCAN cycle 2 aborts the pixel and clears front
    nv = 0;
    h_count = CX'(75); v_count = CY'(75);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    if (pixel_valid) nv++;
    tick();
    if (pixel_valid) nv++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst overrun", 32'(overrun), 32'd0);
    check("midrst pixel_out", 32'(pixel_out), 32'd0);
    check("midrst rast_block", 32'(rast_block), 32'd0);
    check("midrst rast_h", 32'(rast_h), 32'd0);
    for (int c = 0; c < N + 3; c++) begin
      if (pixel_valid) nv++;
      tick();
    end
    check("midrst no valid", 32'(nv), 32'd0);
    run_pixel(15, 15, 0, exp_lat(-1), "front cleared", -1, -1);

    // Randomized writes/copies against the reference model
    for (int i = 0; i < N; i++) begin
      eback[i] = 1'b0; efront[i] = 1'b0; mback[i] = '0; mfront[i] = '0;
    end
    for (int it = 0; it < 25; it++) begin
      nv = int'($urandom_range(1, 4));
      for (int w = 0; w < nv; w++) begin
        int idx;
        bit en;
        idx = int'($urandom_range(0, 7));
        q.ax = SCX'($urandom_range(0, 63)); q.ay = SCY'($urandom_range(0, 63));
        q.bx = SCX'($urandom_range(0, 63)); q.by = SCY'($urandom_range(0, 63));
        q.cx = SCX'($urandom_range(0, 63)); q.cy = SCY'($urandom_range(0, 63));
        q.dx = SCX'($urandom_range(0, 63)); q.dy = SCY'($urandom_range(0, 63));
        q.block = TOTAL_LED'($urandom_range(0, 15));
        en = ($urandom_range(0, 3) != 0);
        wr(idx, q, en);
        if (idx < N) begin
          mback[idx] = q;
          eback[idx] = en;
        end
        if (w == nv - 1 && $urandom_range(0, 1) == 1) begin
          frame_copy();
          for (int s = 0; s < N; s++) begin
            mfront[s] = mback[s];
            efront[s] = eback[s];
          end
        end
      end
      for (int p = 0; p < 3; p++) begin
        int h, v;
        h = int'($urandom_range(0, 63));
        v = int'($urandom_range(0, 63));
        ref_px(h, v, pix, k);
        run_pixel(h, v, pix, exp_lat(k), $sformatf("rnd%0d.%0d", it, p), -1, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/surface_scheduler.md
Name: surface_scheduler

Overview:
- Shares one combinational `surface` quad rasterizer between N_SURF quad descriptors, using time multiplexing.
- Per-pixel flow: on each pixel strobe, steps through all front-bank slots in priority order and presents each slot's vertices and colour to the rasterizer. Captures the first non-zero hit and emits one resolved pixel word.
- Descriptors are written into a back bank and copied to the front bank at frame start, so a frame always renders from consistent geometry.

Parameters:
- N_SURF, 6, number of quad slots (2..16).
- IDXW, $clog2(N_SURF), slot index width.
- BG, '0, TOTAL_LED-wide pixel word output when no slot hits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  descriptor write request.
- wr_ready  out  1  write accepted when high together with wr_valid.
- wr_idx  in  IDXW  target slot.
- wr_quad  in  $bits(quad_t)  {ax,ay,bx,by,cx,cy,dx,dy,block}; vertices are SCX/SCY wide, block is TOTAL_LED wide.
- wr_enable  in  1  slot-valid bit written with the descriptor (0 disables the slot).
- frame_start  in  1  one-cycle pulse; requests the back-to-front copy.
- pix_en  in  1  one-cycle pulse; start resolving pixel at h_count/v_count.
- h_count  in  CX  pixel column, sampled on pix_en.
- v_count  in  CY  pixel row, sampled on pix_en.
- rast_ax..rast_dy  out  SCX/SCY each  vertices driven to the rasterizer.
- rast_block  out  TOTAL_LED  colour driven to the rasterizer.
- rast_h  out  CX  latched column driven to the rasterizer.
- rast_v  out  CY  latched row driven to the rasterizer.
- rast_pixel  in  TOTAL_LED  rasterizer result (combinational from the rast_* outputs).
- pixel_out  out  TOTAL_LED  resolved pixel.
- pixel_valid  out  1  one-cycle strobe; pixel_out is valid.
- busy  out  1  high in SCAN or DONE.
- overrun  out  1  sticky; set when pix_en arrives while busy.

Behaviour:
- Reset:
  - All outputs 0: pixel_out, pixel_valid, busy, overrun, all rast_*.
  - wr_ready 0 during the reset cycle, 1 afterwards.
  - Front and back slot-valid bits cleared; swap_pending cleared; FSM goes to IDLE.
  - Reset mid-scan aborts the scan with no pixel_valid.
- Write path:
  - wr_ready is 1 whenever not in reset.
  - On wr_valid&&wr_ready, back[wr_idx] <= {wr_quad, wr_enable}.
  - wr_idx >= N_SURF: the write is accepted and dropped.
- Frame copy:
  - frame_start sets swap_pending.
  - In any IDLE cycle with swap_pending, front <= back (all slots) and swap_pending clears. A copy never occurs during SCAN/DONE.
  - Write and copy in the same cycle: front takes the pre-write back contents; the write lands in back only.
- FSM states IDLE, SCAN, DONE:
  - IDLE + pix_en (at cycle t):
    - rast_h/rast_v <= h_count/v_count; idx <= 0; hit <= 0; pixel_out unchanged; goes to SCAN.
    - If the copy also fires this cycle, the scan uses the new front.
  - SCAN:
    - rast_* are registered from front[idx]. Slot k is presented during cycle t+1+k.
    - At each SCAN cycle, if !hit && front_valid[idx] && rast_pixel != 0: hit <= 1, res <= rast_pixel.
    - A disabled slot drives rast_block = 0 and never hits.
    - idx increments each cycle; after idx == N_SURF-1, goes to DONE.
  - DONE (cycle t+N_SURF+1):
    - pixel_out <= hit ? res : BG; pixel_valid is 1 for exactly this cycle; goes to IDLE.
  - Fixed latency: pix_en to pixel_valid is N_SURF+1 cycles. Minimum pix_en spacing is N_SURF+2 cycles.
- pix_en while busy: ignored and overrun <= 1. overrun clears only on reset.
- Priority: the lowest slot index wins. Ties and overlaps are resolved only by index.
- Arithmetic: no arithmetic beyond the idx counter. Vertex fields pass through unmodified; their signedness is interpreted by the rasterizer.

Optional Feature:
- SURFACE_SCHED_EARLY_EXIT_EN defined:
  - SCAN goes to DONE in the cycle after the first hit. Latency is variable, k+2 cycles for a hit in slot k.
  - busy falls correspondingly earlier.
- Undefined: fixed N_SURF+1 latency as above.

Decomposition:
- Add to the `coordinates` package:
  - quad_t packed struct {ax,ay,bx,by,cx,cy,dx,dy,block}.
  - sched_state_t enum {IDLE,SCAN,DONE}.
- Sub-module surface_slot_bank: double-buffered register file holding back/front arrays and valid bits, with write port, copy strobe and front read mux.
- The `surface` rasterizer is instantiated by the parent, not inside this block.

Test Plan:
- After reset, write slot 0 = square (10,10)-(20,10)-(20,20)-(10,20) with block=0x3, enabled; pulse frame_start; pix_en at (15,15) -> pixel_valid after N_SURF+1 cycles with pixel_out=0x3. pix_en at (5,5) -> pixel_out=BG.
- Slots 1 and 3 hold overlapping quads with blocks 0x5 and 0x9; pixel inside both -> pixel_out=0x5. Disable slot 1 (wr_enable=0) and copy -> 0x9.
- Write slot 2 mid-frame without frame_start -> output unchanged. After frame_start and an IDLE cycle -> new colour.
- frame_start during SCAN -> current pixel uses old data; copy occurs in the first IDLE cycle and the next pixel uses new data.
- pix_en 3 cycles after a previous pix_en -> second pix_en ignored, overrun=1, exactly one pixel_valid.
- Assert reset at SCAN cycle 2 -> no pixel_valid; all outputs 0; pix_en at (15,15) after reset yields BG (front cleared). With SURFACE_SCHED_EARLY_EXIT_EN and a slot-0 hit -> pixel_valid 2 cycles after pix_en.
